fib_result_checker: RTL and testbench

- Consumer side of the Fibonacci instruction-sequencer test path. It observes completed results leaving the Decoder/ALU datapath (ALUBus plus Flags) with a valid strobe.
- It independently regenerates the expected Fibonacci terms, checks each observed result in order, and latches a PASS/FAIL verdict with error diagnostics.
- It drives the board 7-segment display with status.
- It sits beside the sequencer on the lab top level and replaces manual register inspection.

---
 rtl/fib_result_checker_pkg.sv | 19 +
 rtl/fib_result_checker_hex_to_7seg.sv | 31 +++
 rtl/fib_result_checker.sv | 109 ++++++++++
 tb/tb_fib_result_checker.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fib_result_checker_pkg.sv
// Shared definitions for the Fibonacci result checker: FSM states, display glyphs
// and Flags bus bit positions.
package fib_result_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_e;

    // Active-low {g,f,e,d,c,b,a} glyphs
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_P    = 7'b0001100;
    localparam logic [6:0] SEG_F    = 7'b0001110;

    localparam int FLAG_CARRY = 0;

endpackage

// File: rtl/fib_result_checker_hex_to_7seg.sv
// Combinational 4-bit hex digit to active-low 7-segment {g,f,e,d,c,b,a} decoder.
module hex_to_7seg (
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // NOTE: the default assignment before the case guarantees no latch is inferred.
    always_comb begin
        seg_o = 7'b1111111;
        case (digit_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/fib_result_checker.sv
// Checks a stream of ALU results against a locally regenerated Fibonacci sequence
// and latches a PASS/FAIL verdict with first-error diagnostics and a 7-seg status.
module fib_result_checker
    import fib_result_checker_pkg::*;
#(
    parameter int          NUM_TERMS   = 14,
    parameter logic [15:0] FIRST_TERM  = 16'd1,
    parameter logic [15:0] SECOND_TERM = 16'd2,
    parameter logic [4:0]  FLAG_MASK   = 5'(1 << FLAG_CARRY)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        result_valid,
    input  logic [15:0] result,
    input  logic [4:0]  flags,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  match_count,
    output logic [4:0]  err_index,
    output logic [15:0] err_value,
    output logic [6:0]  display
);

    localparam logic [4:0] LAST_COUNT = 5'(NUM_TERMS);

    state_e      state_q;
    logic        busy_q, done_q, pass_q;
    logic [4:0]  match_count_q, err_index_q;
    logic [15:0] err_value_q;
    logic [6:0]  display_q;
    logic [15:0] exp_cur_q, exp_next_q;

    logic [4:0]  match_count_d;
    logic        is_match;
    logic [3:0]  seg_digit;
    logic [6:0]  seg_hex;

    assign match_count_d = match_count_q + 5'd1;
    assign is_match      = (result == exp_cur_q) && ((flags & FLAG_MASK) == 5'd0);

    // A (re)start always shows digit 0; otherwise show the count this edge will reach.
    assign seg_digit = start ? 4'd0 : match_count_d[3:0];

    hex_to_7seg u_hex (
        .digit_i (seg_digit),
        .seg_o   (seg_hex)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            match_count_q <= 5'd0;
            err_index_q   <= 5'd0;
            err_value_q   <= 16'd0;
            display_q     <= SEG_DASH;
            exp_cur_q     <= FIRST_TERM;
            exp_next_q    <= SECOND_TERM;
        end else if (start) begin
            state_q       <= RUN;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            match_count_q <= 5'd0;
            err_index_q   <= 5'd0;
            err_value_q   <= 16'd0;
            display_q     <= seg_hex;
            exp_cur_q     <= FIRST_TERM;
            exp_next_q    <= SECOND_TERM;
        end else if (state_q == RUN && result_valid) begin
            if (is_match) begin
                match_count_q <= match_count_d;
                exp_cur_q     <= exp_next_q;
                exp_next_q    <= exp_cur_q + exp_next_q;
                if (match_count_d == LAST_COUNT) begin
                    state_q   <= PASS;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    pass_q    <= 1'b1;
                    display_q <= SEG_P;
                end else begin
                    display_q <= seg_hex;
                end
            end else begin
                state_q     <= FAIL;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                pass_q      <= 1'b0;
                err_index_q <= match_count_q;
                err_value_q <= result;
                display_q   <= SEG_F;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign match_count = match_count_q;
    assign err_index   = err_index_q;
    assign err_value   = err_value_q;
    assign display     = display_q;

endmodule

// File: tb/tb_fib_result_checker.sv
// Scoreboard bench for fib_result_checker: each strobe pushes its expected outputs,
// a monitor pops and compares one cycle after the DUT samples the strobe.
module tb_fib_result_checker;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [4:0]  cnt;
        logic [4:0]  eidx;
        logic [15:0] eval;
        logic [6:0]  disp;
    } exp_t;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [15:0] FIB [14] = '{
        16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21,
        16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610};
    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_P = 7'b0001100;
    localparam logic [6:0] GLYPH_F = 7'b0001110;

    logic        clk, reset, start, result_valid;
    logic [15:0] result;
    logic [4:0]  flags;
    logic        busy, done, pass;
    logic [4:0]  match_count, err_index;
    logic [15:0] err_value;
    logic [6:0]  display;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    fib_result_checker dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .result_valid (result_valid),
        .result       (result),
        .flags        (flags),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .match_count  (match_count),
        .err_index    (err_index),
        .err_value    (err_value),
        .display      (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t idle_exp();
        return '{busy: 1'b0, done: 1'b0, pass: 1'b0, cnt: 5'd0, eidx: 5'd0, eval: 16'd0, disp: DASH};
    endfunction

    function automatic exp_t run_exp(input int cnt);
        return '{busy: 1'b1, done: 1'b0, pass: 1'b0, cnt: 5'(cnt), eidx: 5'd0, eval: 16'd0,
                 disp: HEX[cnt % 16]};
    endfunction

    function automatic exp_t pass_exp();
        return '{busy: 1'b0, done: 1'b1, pass: 1'b1, cnt: 5'd14, eidx: 5'd0, eval: 16'd0, disp: GLYPH_P};
    endfunction

    function automatic exp_t fail_exp(input int cnt, input int idx, input logic [15:0] val);
        return '{busy: 1'b0, done: 1'b1, pass: 1'b0, cnt: 5'(cnt), eidx: 5'(idx), eval: val, disp: GLYPH_F};
    endfunction

    task automatic check_now(input string tag, input exp_t e);
        check({tag, ".busy"},        32'(busy),        32'(e.busy));
        check({tag, ".done"},        32'(done),        32'(e.done));
        check({tag, ".pass"},        32'(pass),        32'(e.pass));
        check({tag, ".match_count"}, 32'(match_count), 32'(e.cnt));
        check({tag, ".err_index"},   32'(err_index),   32'(e.eidx));
        check({tag, ".err_value"},   32'(err_value),   32'(e.eval));
        check({tag, ".display"},     32'(display),     32'(e.disp));
    endtask

    // Monitor: any start/valid sampled out of reset yields a new output state.
    initial begin
        forever begin
            logic strobe;
            @(posedge clk);
            strobe = (start || result_valid) && !reset;
            #1;
            if (strobe) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    check_now("mon", exp_q.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic s, input logic v, input logic [15:0] r, input logic [4:0] f,
                         input exp_t e);
        @(negedge clk);
        start        = s;
        result_valid = v;
        result       = r;
        flags        = f;
        exp_q.push_back(e);
        @(negedge clk);
        start        = 1'b0;
        result_valid = 1'b0;
        result       = 16'hxxxx;
        flags        = 5'd0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    // Send terms 0..n-1; term bad_idx is replaced by bad_val and ends the run in FAIL.
    task automatic feed(input int n, input int bad_idx, input logic [15:0] bad_val);
        for (int i = 0; i < n; i++) begin
            gap();
            if (i == bad_idx) begin
                drive(1'b0, 1'b1, bad_val, 5'd0, fail_exp(i, i, bad_val));
                return;
            end
            drive(1'b0, 1'b1, FIB[i], 5'd0, (i + 1 == 14) ? pass_exp() : run_exp(i + 1));
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; result_valid = 1'b0; result = 16'd0; flags = 5'd0;
        #1;
        check_now("reset", idle_exp());
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: full correct run
        drive(1'b1, 1'b0, 16'd0, 5'd0, run_exp(0));
        feed(14, -1, 16'd0);

        // 2: term 4 corrupted, later valids ignored
        drive(1'b1, 1'b0, 16'd0, 5'd0, run_exp(0));
        feed(14, 4, 16'd9);
        drive(1'b0, 1'b1, 16'd13, 5'd0, fail_exp(4, 4, 16'd9));
        drive(1'b0, 1'b1, 16'd8,  5'd0, fail_exp(4, 4, 16'd9));

        // 3: correct value with carry flag set
        drive(1'b1, 1'b0, 16'd0, 5'd0, run_exp(0));
        drive(1'b0, 1'b1, 16'd1, 5'd1, fail_exp(0, 0, 16'd1));

        // 5: start wins over a simultaneous valid, then a full run
        drive(1'b1, 1'b0, 16'd0, 5'd0, run_exp(0));
        feed(3, -1, 16'd0);
        drive(1'b1, 1'b1, 16'd5, 5'd0, run_exp(0));
        feed(14, -1, 16'd0);

        // 6: re-arm from PASS must reload the expected first term
        drive(1'b1, 1'b0, 16'd0, 5'd0, run_exp(0));
        drive(1'b0, 1'b1, 16'd2, 5'd0, fail_exp(0, 0, 16'd2));

        // 4: asynchronous reset mid-run
        drive(1'b1, 1'b0, 16'd0, 5'd0, run_exp(0));
        feed(5, -1, 16'd0);
        drain();
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_now("async_reset", idle_exp());
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 1'b1, 16'd1, 5'd0, idle_exp());
        drive(1'b0, 1'b1, 16'd2, 5'd0, idle_exp());

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
